// File: rtl/bullcow_arena.sv
// Multi-player Bulls-and-Cows engine.
// Players enter distinct-digit secrets in turn, then guess round-robin; player p attacks
// the secret of player (p+1) mod NUM_PLAYERS. Results are registered with a valid strobe
// and per-player scores persist across rounds until reset.
// Optional macro BULLCOW_TRY_LIMIT_EN adds a per-round try limit that ends in a DRAW state.
module bullcow_arena #(
  parameter int unsigned NUM_DIGITS  = 4,
  parameter int unsigned DIGIT_W     = 4,
  parameter int unsigned NUM_PLAYERS = 2,
  parameter int unsigned SCORE_W     = 8,
  parameter int unsigned MAX_TRIES   = 8,
  localparam int unsigned EW = NUM_DIGITS * DIGIT_W,
  localparam int unsigned CW = $clog2(NUM_DIGITS + 1),
  localparam int unsigned PW = ($clog2(NUM_PLAYERS) > 1) ? $clog2(NUM_PLAYERS) : 1
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic                           enter,
  input  logic [EW-1:0]                  guess_in,
  output logic [2:0]                     game_state,
  output logic [PW-1:0]                  cur_player,
  output logic [CW-1:0]                  bull_count,
  output logic [CW-1:0]                  cow_count,
  output logic                           result_valid,
  output logic                           invalid_entry,
  output logic [PW-1:0]                  winner,
  output logic [NUM_PLAYERS*SCORE_W-1:0] scores
);

  typedef enum logic [2:0] {
    StSetup = 3'b000,
    StGuess = 3'b010,
    StCheck = 3'b011,
    StDraw  = 3'b110,
    StEnd   = 3'b111
  } state_e;

  state_e             state_q, state_d;
  logic [PW-1:0]      cur_q, cur_d, winner_q, winner_d, next_player;
  logic [CW-1:0]      bull_q, bull_d, cow_q, cow_d, bulls, cows;
  logic               rv_q, rv_d, inv_q, inv_d;
  logic               enter_q, cmd, entry_valid, secret_we, score_inc;
  logic [EW-1:0]      guess_q, guess_d, target;
  logic [EW-1:0]      secret_q [NUM_PLAYERS];
  logic [SCORE_W-1:0] score_q [NUM_PLAYERS];

`ifdef BULLCOW_TRY_LIMIT_EN
  localparam int unsigned TotalTries = NUM_PLAYERS * MAX_TRIES;
  localparam int unsigned TW = ($clog2(TotalTries) > 1) ? $clog2(TotalTries) : 1;
  logic [TW-1:0] tries_q, tries_d;
`else
  logic unused_max_tries;
  assign unused_max_tries = (MAX_TRIES != 0);
`endif

  assign cmd = enter & ~enter_q;

  // Explicit wrap so non-power-of-2 player counts cycle correctly.
  assign next_player = (cur_q == PW'(NUM_PLAYERS - 1)) ? '0 : cur_q + PW'(1);
  assign target      = secret_q[next_player];

  // An entry is valid only if every digit differs from every other digit.
  always_comb begin
    entry_valid = 1'b1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      for (int j = i + 1; j < NUM_DIGITS; j++) begin
        if (guess_in[i*DIGIT_W +: DIGIT_W] == guess_in[j*DIGIT_W +: DIGIT_W]) begin
          entry_valid = 1'b0;
        end
      end
    end
  end

  // Bull/cow scoring of the registered guess against the attacked secret.
  always_comb begin
    bulls = '0;
    cows  = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      for (int j = 0; j < NUM_DIGITS; j++) begin
        if (guess_q[i*DIGIT_W +: DIGIT_W] == target[j*DIGIT_W +: DIGIT_W]) begin
          if (i == j) bulls = bulls + CW'(1);
          else        cows  = cows + CW'(1);
        end
      end
    end
  end

  // Game FSM next-state and registered-output updates.
  always_comb begin
    state_d   = state_q;
    cur_d     = cur_q;
    winner_d  = winner_q;
    bull_d    = bull_q;
    cow_d     = cow_q;
    guess_d   = guess_q;
    rv_d      = 1'b0;
    inv_d     = 1'b0;
    secret_we = 1'b0;
    score_inc = 1'b0;
`ifdef BULLCOW_TRY_LIMIT_EN
    tries_d   = tries_q;
`endif
    unique case (state_q)
      StSetup: begin
`ifdef BULLCOW_TRY_LIMIT_EN
        tries_d = '0;
`endif
        if (cmd) begin
          if (!entry_valid) begin
            inv_d = 1'b1;
          end else begin
            secret_we = 1'b1;
            if (cur_q == PW'(NUM_PLAYERS - 1)) begin
              cur_d   = '0;
              state_d = StGuess;
            end else begin
              cur_d = cur_q + PW'(1);
            end
          end
        end
      end
      StGuess: begin
        if (cmd) begin
          if (!entry_valid) begin
            inv_d = 1'b1;
          end else begin
            guess_d = guess_in;
            state_d = StCheck;
          end
        end
      end
      StCheck: begin
        rv_d   = 1'b1;
        bull_d = bulls;
        cow_d  = cows;
        if (bulls == CW'(NUM_DIGITS)) begin
          winner_d  = cur_q;
          score_inc = 1'b1;
          state_d   = StEnd;
        end else begin
          cur_d   = next_player;
          state_d = StGuess;
`ifdef BULLCOW_TRY_LIMIT_EN
          tries_d = tries_q + TW'(1);
          if (tries_q == TW'(TotalTries - 1)) state_d = StDraw;
`endif
        end
      end
      StDraw, StEnd: begin
        if (cmd) begin
          cur_d   = '0;
          state_d = StSetup;
        end
      end
      default: state_d = StSetup;
    endcase
  end

  // State, result and history registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= StSetup;
      cur_q    <= '0;
      winner_q <= '0;
      bull_q   <= '0;
      cow_q    <= '0;
      guess_q  <= '0;
      rv_q     <= 1'b0;
      inv_q    <= 1'b0;
      enter_q  <= 1'b0;
`ifdef BULLCOW_TRY_LIMIT_EN
      tries_q  <= '0;
`endif
    end else begin
      state_q  <= state_d;
      cur_q    <= cur_d;
      winner_q <= winner_d;
      bull_q   <= bull_d;
      cow_q    <= cow_d;
      guess_q  <= guess_d;
      rv_q     <= rv_d;
      inv_q    <= inv_d;
      enter_q  <= enter;
`ifdef BULLCOW_TRY_LIMIT_EN
      tries_q  <= tries_d;
`endif
    end
  end

  // Per-player secrets and saturating scores.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int p = 0; p < NUM_PLAYERS; p++) begin
        secret_q[p] <= '0;
        score_q[p]  <= '0;
      end
    end else begin
      for (int p = 0; p < NUM_PLAYERS; p++) begin
        if (secret_we && cur_q == PW'(p)) secret_q[p] <= guess_in;
        if (score_inc && cur_q == PW'(p) && score_q[p] != '1) begin
          score_q[p] <= score_q[p] + SCORE_W'(1);
        end
      end
    end
  end

  for (genvar p = 0; p < NUM_PLAYERS; p++) begin : g_scores
    assign scores[p*SCORE_W +: SCORE_W] = score_q[p];
  end

  assign game_state    = state_q;
  assign cur_player    = cur_q;
  assign bull_count    = bull_q;
  assign cow_count     = cow_q;
  assign result_valid  = rv_q;
  assign invalid_entry = inv_q;
  assign winner        = winner_q;

endmodule

// File: tb/tb_bullcow_arena.sv
// Directed bench for bullcow_arena (4 digits, 2 players, 8-bit scores, MAX_TRIES=2).
module tb_bullcow_arena;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        enter = 1'b0;
  logic [15:0] guess_in = '0;
  logic [2:0]  game_state;
  logic        cur_player;
  logic [2:0]  bull_count, cow_count;
  logic        result_valid, invalid_entry, winner;
  logic [15:0] scores;

  int tests = 0;
  int fails = 0;
  int pulses;

  bullcow_arena #(
    .NUM_DIGITS (4),
    .DIGIT_W    (4),
    .NUM_PLAYERS(2),
    .SCORE_W    (8),
    .MAX_TRIES  (2)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .enter        (enter),
    .guess_in     (guess_in),
    .game_state   (game_state),
    .cur_player   (cur_player),
    .bull_count   (bull_count),
    .cow_count    (cow_count),
    .result_valid (result_valid),
    .invalid_entry(invalid_entry),
    .winner       (winner),
    .scores       (scores)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Rising edge of enter is sampled at the next clock edge; returns just after that edge.
  task automatic press(input logic [15:0] v);
    guess_in = v;
    enter    = 1'b1;
    tick();
    enter    = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    tick();
  endtask

  initial begin
    do_reset();
    chk("reset_state", 32'(game_state), 32'h0);
    chk("reset_cur", 32'(cur_player), 32'h0);
    chk("reset_bull", 32'(bull_count), 32'h0);
    chk("reset_cow", 32'(cow_count), 32'h0);
    chk("reset_rv", 32'(result_valid), 32'h0);
    chk("reset_inv", 32'(invalid_entry), 32'h0);
    chk("reset_winner", 32'(winner), 32'h0);
    chk("reset_scores", 32'(scores), 32'h0);

    // Repeated digit in SETUP is rejected.
    press(16'h1123);
    chk("setup_inv_pulse", 32'(invalid_entry), 32'h1);
    chk("setup_inv_state", 32'(game_state), 32'h0);
    chk("setup_inv_cur", 32'(cur_player), 32'h0);
    tick();
    chk("setup_inv_clear", 32'(invalid_entry), 32'h0);

    press(16'h4321);
    chk("setup_p0_state", 32'(game_state), 32'h0);
    chk("setup_p0_cur", 32'(cur_player), 32'h1);
    tick();
    press(16'h8765);
    chk("setup_done_state", 32'(game_state), 32'h2);
    chk("setup_done_cur", 32'(cur_player), 32'h0);
    tick();

    // P0 vs 8765: digits 6,5 swapped -> 2 bulls, 2 cows.
    press(16'h8756);
    chk("mixed_check_state", 32'(game_state), 32'h3);
    chk("mixed_rv_early", 32'(result_valid), 32'h0);
    tick();
    chk("mixed_rv", 32'(result_valid), 32'h1);
    chk("mixed_bull", 32'(bull_count), 32'h2);
    chk("mixed_cow", 32'(cow_count), 32'h2);
    chk("mixed_cur", 32'(cur_player), 32'h1);
    chk("mixed_state", 32'(game_state), 32'h2);
    tick();
    chk("mixed_rv_drop", 32'(result_valid), 32'h0);
    chk("mixed_bull_hold", 32'(bull_count), 32'h2);

    // Invalid guess keeps GUESS and the current player.
    press(16'h1231);
    chk("guess_inv_pulse", 32'(invalid_entry), 32'h1);
    chk("guess_inv_state", 32'(game_state), 32'h2);
    chk("guess_inv_cur", 32'(cur_player), 32'h1);
    tick();

    // P1 vs 4321 with 1234 -> all cows.
    press(16'h1234);
    tick();
    chk("p1_cows_bull", 32'(bull_count), 32'h0);
    chk("p1_cows_cow", 32'(cow_count), 32'h4);
    chk("p1_cows_cur", 32'(cur_player), 32'h0);

    // P0 vs 8765 with 5678 -> all cows.
    press(16'h5678);
    tick();
    chk("p0_cows_bull", 32'(bull_count), 32'h0);
    chk("p0_cows_cow", 32'(cow_count), 32'h4);
    chk("p0_cows_cur", 32'(cur_player), 32'h1);

    // P1 cracks 4321.
    press(16'h4321);
    tick();
    chk("win_rv", 32'(result_valid), 32'h1);
    chk("win_bull", 32'(bull_count), 32'h4);
    chk("win_cow", 32'(cow_count), 32'h0);
    chk("win_state", 32'(game_state), 32'h7);
    chk("win_winner", 32'(winner), 32'h1);
    chk("win_scores", 32'(scores), 32'h0100);
    tick();
    press(16'h0000);
    chk("end_to_setup", 32'(game_state), 32'h0);
    chk("end_cur", 32'(cur_player), 32'h0);
    chk("end_scores_kept", 32'(scores), 32'h0100);
    tick();

    // Held enter yields one command only.
    press(16'h4321);
    tick();
    press(16'h8765);
    tick();
    guess_in = 16'h8756;
    enter    = 1'b1;
    pulses   = 0;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (result_valid) pulses++;
    end
    enter = 1'b0;
    chk("held_one_check", 32'(pulses), 32'h1);
    chk("held_state", 32'(game_state), 32'h2);
    chk("held_cur", 32'(cur_player), 32'h1);
    tick();

    // Asynchronous reset while in CHECK.
    press(16'h1234);
    chk("pre_reset_check", 32'(game_state), 32'h3);
    reset = 1'b1;
    #1;
    chk("rst_state", 32'(game_state), 32'h0);
    chk("rst_cur", 32'(cur_player), 32'h0);
    chk("rst_scores", 32'(scores), 32'h0);
    chk("rst_winner", 32'(winner), 32'h0);
    tick();
    chk("rst_bull", 32'(bull_count), 32'h0);
    chk("rst_rv", 32'(result_valid), 32'h0);
    reset = 1'b0;
    tick();

    // P0 wins 256 rounds; 8-bit score saturates at ff.
    for (int r = 0; r < 256; r++) begin
      press(16'h4321);
      tick();
      press(16'h8765);
      tick();
      press(16'h8765);
      tick();
      if (r == 0) chk("sat_first", 32'(scores), 32'h0001);
      if (r == 254) chk("sat_reach", 32'(scores), 32'h00ff);
      if (r == 255) chk("sat_hold", 32'(scores), 32'h00ff);
      press(16'h0000);
      tick();
    end
    chk("sat_setup", 32'(game_state), 32'h0);

`ifdef BULLCOW_TRY_LIMIT_EN
    do_reset();
    press(16'h4321);
    tick();
    press(16'h8765);
    tick();
    for (int m = 0; m < 4; m++) begin
      press((m % 2 == 0) ? 16'h1234 : 16'h5678);
      tick();
    end
    chk("draw_state", 32'(game_state), 32'h6);
    chk("draw_scores", 32'(scores), 32'h0);
    chk("draw_winner", 32'(winner), 32'h0);
    press(16'h0000);
    chk("draw_to_setup", 32'(game_state), 32'h0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
